// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the two-requester memory request arbiter.
package mem_arb_pkg;

  // Transaction sequencer states; encodings are fixed for debug visibility.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Direction encodings on req_rd_wr_i / m_rd_wr_o.
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam int ADDR_W_DEF  = 23;
  localparam int TIMEOUT_DEF = 16;

  // Expand a requester index into a one-hot owner mask.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for mem_req_arbiter.
interface mem_req_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [1:0]          req_valid_i;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [1:0]          req_rd_wr_i;
  logic [1:0]          addr_ready_o;
  logic [1:0]          w_ready_o;
  logic [1:0]          r_b_valid_o;
  logic [1:0]          err_o;
  logic [ADDR_W-1:0]   m_addr_o;
  logic                m_rd_wr_o;
  logic                m_addr_valid_o;
  logic                m_addr_ready_i;
  logic                m_w_ready_i;
  logic                m_r_b_valid_i;
  logic [1:0]          grant_o;
  logic                busy_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_addr_i, req_rd_wr_i,
    input  m_addr_ready_i, m_w_ready_i, m_r_b_valid_i,
    output addr_ready_o, w_ready_o, r_b_valid_o, err_o,
    output m_addr_o, m_rd_wr_o, m_addr_valid_o, grant_o, busy_o
  );

  // Environment side: requesters plus the downstream port.
  modport master (
    output req_valid_i, req_addr_i, req_rd_wr_i,
    output m_addr_ready_i, m_w_ready_i, m_r_b_valid_i,
    input  addr_ready_o, w_ready_o, r_b_valid_o, err_o,
    input  m_addr_o, m_rd_wr_o, m_addr_valid_o, grant_o, busy_o
  );
endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational 2-way round-robin selector: on contention the requester
// that did not own the bus last time wins.
module mem_arb_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       any_valid_o
);

  // Pick the winner from the valid mask and the previous owner.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign any_valid_o = |valid_i;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter and per-transaction sequencer for the shared memory
// request port, with a per-phase watchdog that returns an error response.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_req_arbiter_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_wr_q, rd_wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;

  logic [1:0]        pick_s;
  logic              any_valid_s;
  logic [1:0]        own_oh_s;
  logic              hs_s;
  arb_state_e        hs_state_s;
  logic [1:0]        addr_ready_s, w_ready_s, rbv_s, err_s;

  mem_arb_rr_pick u_pick (
    .valid_i      (bus.req_valid_i),
    .last_grant_i (last_q),
    .grant_o      (pick_s),
    .any_valid_o  (any_valid_s)
  );

  assign own_oh_s = idx_to_onehot(idx_q);

  // State, capture and watchdog registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      addr_q  <= '0;
      rd_wr_q <= RD;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rd_wr_q <= rd_wr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state, watchdog and owner-gated handshake outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    rd_wr_d      = rd_wr_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    hs_s         = 1'b0;
    hs_state_s   = IDLE;
    addr_ready_s = 2'b00;
    w_ready_s    = 2'b00;
    rbv_s        = 2'b00;
    err_s        = 2'b00;

    // Phase handshake and where it leads; inputs outside their phase are ignored.
    case (state_q)
      ADDR: begin
        hs_s         = bus.m_addr_ready_i;
        hs_state_s   = (rd_wr_q == WR) ? WDATA : RESP;
        addr_ready_s = own_oh_s & {2{bus.m_addr_ready_i}};
      end
      WDATA: begin
        hs_s       = bus.m_w_ready_i;
        hs_state_s = RESP;
        w_ready_s  = own_oh_s & {2{bus.m_w_ready_i}};
      end
      RESP: begin
        hs_s       = bus.m_r_b_valid_i;
        hs_state_s = IDLE;
        rbv_s      = own_oh_s & {2{bus.m_r_b_valid_i}};
      end
      default: begin
        hs_s       = 1'b0;
        hs_state_s = IDLE;
      end
    endcase

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (any_valid_s) begin
        idx_d   = pick_s[1];
        addr_d  = pick_s[1] ? bus.req_addr_i[2*ADDR_W-1:ADDR_W] : bus.req_addr_i[ADDR_W-1:0];
        rd_wr_d = pick_s[1] ? bus.req_rd_wr_i[1] : bus.req_rd_wr_i[0];
        state_d = ADDR;
      end else begin
        state_d = IDLE;
      end
    end else if (hs_s) begin
      // A handshake on the expiry cycle still wins over the watchdog.
      state_d = hs_state_s;
      cnt_d   = '0;
      if (hs_state_s == IDLE) begin
        last_d = idx_q;
      end else begin
        last_d = last_q;
      end
    end else if (cnt_q == CNT_LAST) begin
      rbv_s   = own_oh_s;
      err_s   = own_oh_s;
      state_d = IDLE;
      cnt_d   = '0;
      last_d  = idx_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.addr_ready_o   = addr_ready_s;
  assign bus.w_ready_o      = w_ready_s;
  assign bus.r_b_valid_o    = rbv_s;
  assign bus.err_o          = err_s;
  assign bus.m_addr_valid_o = (state_q == ADDR);
  assign bus.m_addr_o       = (state_q == ADDR) ? addr_q : '0;
  assign bus.m_rd_wr_o      = (state_q == ADDR) ? rd_wr_q : 1'b0;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.grant_o        = (state_q != IDLE) ? own_oh_s : 2'b00;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Cycle-vector bench for mem_req_arbiter: a table of per-cycle inputs and
// expected outputs, with expected records passed through a scoreboard queue.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 23;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_req_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]    grant;
    logic          busy;
    logic          mav;
    logic [AW-1:0] maddr;
    logic          mrw;
    logic [1:0]    ar;
    logic [1:0]    wr;
    logic [1:0]    rbv;
    logic [1:0]    err;
  } obs_t;

  typedef struct packed {
    logic          rst_n;
    logic [1:0]    rv;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    rw;
    logic          mar;
    logic          mwr;
    logic          mrb;
    obs_t          exp;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  vec_t cur;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_err_pulses = 0;

  task automatic si(input logic rst_n, input logic [1:0] rv, input logic [1:0] rw,
                    input logic mar, input logic mwr, input logic mrb);
    cur.rst_n = rst_n;
    cur.rv    = rv;
    cur.rw    = rw;
    cur.mar   = mar;
    cur.mwr   = mwr;
    cur.mrb   = mrb;
  endtask

  task automatic add(input logic [1:0] g, input logic busy, input logic mav,
                     input logic [AW-1:0] ma, input logic mrw, input logic [1:0] ar,
                     input logic [1:0] wr, input logic [1:0] rbv, input logic [1:0] err);
    vec_t v;
    v           = cur;
    v.exp.grant = g;
    v.exp.busy  = busy;
    v.exp.mav   = mav;
    v.exp.maddr = ma;
    v.exp.mrw   = mrw;
    v.exp.ar    = ar;
    v.exp.wr    = wr;
    v.exp.rbv   = rbv;
    v.exp.err   = err;
    vecs.push_back(v);
  endtask

  task automatic exp_idle();
    add(2'b00, 1'b0, 1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic exp_addr(input logic [1:0] g, input logic [AW-1:0] ma, input logic mrw, input logic ar);
    add(g, 1'b1, 1'b1, ma, mrw, ar ? g : 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic exp_wdata(input logic [1:0] g, input logic w);
    add(g, 1'b1, 1'b0, '0, 1'b0, 2'b00, w ? g : 2'b00, 2'b00, 2'b00);
  endtask

  task automatic exp_resp(input logic [1:0] g, input logic r, input logic e);
    add(g, 1'b1, 1'b0, '0, 1'b0, 2'b00, 2'b00, r ? g : 2'b00, e ? g : 2'b00);
  endtask

  initial begin
    obs_t o;
    obs_t e;
    logic [1:0]    g;
    logic [AW-1:0] ma;

    // ---- build the vector table ----
    cur = '0;
    si(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); exp_idle();

    // Contested start: requester 0 reads, requester 1 writes.
    cur.a0 = 23'h203100;
    cur.a1 = 23'h000010;
    si(1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0); exp_idle();
    si(1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0); exp_addr(2'b01, 23'h203100, 1'b0, 1'b1);
    si(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1); exp_resp(2'b01, 1'b1, 1'b0);
    si(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0); exp_idle();
    si(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0); exp_addr(2'b10, 23'h000010, 1'b1, 1'b0);
    si(1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0); exp_addr(2'b10, 23'h000010, 1'b1, 1'b1);
    si(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1); exp_wdata(2'b10, 1'b1);
    si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); exp_resp(2'b10, 1'b0, 1'b0);
    si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); exp_resp(2'b10, 1'b1, 1'b0);
    si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); exp_idle();

    // Both always valid, both writing: grants alternate 0,1,0,1.
    cur.a0 = 23'h00AAAA;
    cur.a1 = 23'h055555;
    for (int t = 0; t < 4; t++) begin
      g  = (t % 2 == 1) ? 2'b10 : 2'b01;
      ma = (t % 2 == 1) ? cur.a1 : cur.a0;
      si(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0); exp_idle();
      si(1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0); exp_addr(g, ma, 1'b1, 1'b1);
      si(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0); exp_wdata(g, 1'b1);
      si(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1); exp_resp(g, 1'b1, 1'b0);
    end

    // Stalled response: watchdog expiry, then handshake on the expiry cycle.
    cur.a0 = 23'h123456;
    for (int s = 0; s < 2; s++) begin
      si(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0); exp_idle();
      si(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0); exp_addr(2'b01, 23'h123456, 1'b0, 1'b1);
      for (int k = 0; k < TO; k++) begin
        si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, (s == 1) && (k == TO - 1));
        exp_resp(2'b01, k == TO - 1, (s == 0) && (k == TO - 1));
      end
      si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); exp_idle();
    end

    // Reset during WDATA; the following contested grant goes to requester 0.
    cur.a0 = 23'h011111;
    cur.a1 = 23'h0ABCDE;
    si(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0); exp_idle();
    si(1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0); exp_addr(2'b10, 23'h0ABCDE, 1'b1, 1'b1);
    si(1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0); exp_wdata(2'b10, 1'b0);
    si(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1); exp_idle();
    si(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0); exp_addr(2'b01, 23'h011111, 1'b0, 1'b1);
    si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); exp_resp(2'b01, 1'b1, 1'b0);
    si(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); exp_idle();

    // ---- initial reset ----
    reset              = 1'b0;
    bus.req_valid_i    = 2'b00;
    bus.req_addr_i     = '0;
    bus.req_rd_wr_i    = 2'b00;
    bus.m_addr_ready_i = 1'b0;
    bus.m_w_ready_i    = 1'b0;
    bus.m_r_b_valid_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- reset-state check ----
    if (bus.grant_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.m_addr_valid_o !== 1'b0 ||
        bus.m_addr_o !== '0 || bus.m_rd_wr_o !== 1'b0 || bus.addr_ready_o !== 2'b00 ||
        bus.w_ready_o !== 2'b00 || bus.r_b_valid_o !== 2'b00 || bus.err_o !== 2'b00) begin
      n_bad++;
      $display("FAIL reset state: grant=%b busy=%b mav=%b maddr=%h mrw=%b ar=%b wr=%b rbv=%b err=%b",
               bus.grant_o, bus.busy_o, bus.m_addr_valid_o, bus.m_addr_o, bus.m_rd_wr_o,
               bus.addr_ready_o, bus.w_ready_o, bus.r_b_valid_o, bus.err_o);
    end

    // ---- apply and compare ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset              = vecs[i].rst_n;
      bus.req_valid_i    = vecs[i].rv;
      bus.req_addr_i     = {vecs[i].a1, vecs[i].a0};
      bus.req_rd_wr_i    = vecs[i].rw;
      bus.m_addr_ready_i = vecs[i].mar;
      bus.m_w_ready_i    = vecs[i].mwr;
      bus.m_r_b_valid_i  = vecs[i].mrb;
      sb.push_back(vecs[i].exp);
      #2;
      o.grant = bus.grant_o;
      o.busy  = bus.busy_o;
      o.mav   = bus.m_addr_valid_o;
      o.maddr = bus.m_addr_o;
      o.mrw   = bus.m_rd_wr_o;
      o.ar    = bus.addr_ready_o;
      o.wr    = bus.w_ready_o;
      o.rbv   = bus.r_b_valid_o;
      o.err   = bus.err_o;
      if (o.err !== 2'b00) begin
        n_err_pulses++;
      end
      e = sb.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL vec %0d: got grant=%b busy=%b mav=%b maddr=%h mrw=%b ar=%b wr=%b rbv=%b err=%b, want grant=%b busy=%b mav=%b maddr=%h mrw=%b ar=%b wr=%b rbv=%b err=%b",
                 i, o.grant, o.busy, o.mav, o.maddr, o.mrw, o.ar, o.wr, o.rbv, o.err,
                 e.grant, e.busy, e.mav, e.maddr, e.mrw, e.ar, e.wr, e.rbv, e.err);
      end
    end

    // ---- expired-wait check ----
    if (n_err_pulses != 1) begin
      n_bad++;
      $display("FAIL watchdog: saw %0d error pulses, want 1", n_err_pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule
